// File: rtl/av_recvpacket_if.sv
// ----------------------------------------------------------------------------
// av_recvpacket_if
// Avalon-MM slave bus bundle for the UDP receive-packet register block.
//   address   [3:0]   word address
//   write             write strobe
//   read              read strobe
//   writedata [31:0]  write data
//   readdata  [31:0]  registered read data (driven by the slave)
// Modports: master (CPU / bus side), slave (register block).
// ----------------------------------------------------------------------------
interface av_recvpacket_if;
  logic [3:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output write, output read, output writedata,
                  input readdata);
  modport slave  (input address, input write, input read, input writedata,
                  output readdata);
endinterface

// File: rtl/av_recvpacket.sv
// ----------------------------------------------------------------------------
// av_recvpacket
// Avalon-MM register block for the UDP receive path. Captures one received
// packet descriptor (source MAC/IP/port, destination port, length, checksum),
// holds it until the CPU acknowledges it, filters on local port, counts
// accepted and dropped packets and raises an interrupt.
//
// Parameters:
//   LOCAL_PORT_RST  reset value of the local-port filter register
//   COUNT_W         width of RX/drop counters (1..32), zero-extended on read
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   bus             Avalon-MM slave (address/write/read/writedata/readdata)
//   irq             registered interrupt: IRQ_EN & (PENDING | OVERFLOW)
//   rx_*            descriptor from the UDP RX engine, qualified by rx_valid
//   rx_busy         1 while a descriptor is pending
// Optional feature: define AVRX_TIMESTAMP_EN to add a free-running cycle
// counter whose value is latched on each capture and read at address 10.
// ----------------------------------------------------------------------------
module av_recvpacket #(
  parameter logic [15:0] LOCAL_PORT_RST = 16'hAAAA,
  parameter int          COUNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  av_recvpacket_if.slave    bus,
  output logic              irq,
  input  logic              rx_valid,
  input  logic              rx_crc_err,
  input  logic [47:0]       rx_src_mac,
  input  logic [31:0]       rx_src_ip,
  input  logic [15:0]       rx_src_port,
  input  logic [15:0]       rx_dst_port,
  input  logic [15:0]       rx_length,
  input  logic [15:0]       rx_checksum,
  output logic              rx_busy
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t state_q, state_d;

  logic [47:0] desc_mac;
  logic [31:0] desc_ip;
  logic [15:0] desc_sport, desc_dport, desc_len, desc_csum;

  logic [COUNT_W-1:0] rx_count, drop_count;
  logic        overflow, irq_en, filter_en;
  logic [15:0] local_port;

  logic        wr_ctrl, w1c_pend, w1c_ovf, wr_lport, wr_rxcnt, wr_dropcnt;
  logic        accept, capture, drop, ovf_set;
  logic [31:0] rd_mux, ts_rd;
  logic        unused_wd;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (&c) ? c : c + COUNT_W'(1);
  endfunction

  assign wr_ctrl    = bus.write && (bus.address == 4'd0);
  assign w1c_pend   = wr_ctrl && bus.writedata[0];
  assign w1c_ovf    = wr_ctrl && bus.writedata[1];
  assign wr_lport   = bus.write && (bus.address == 4'd2);
  assign wr_rxcnt   = bus.write && (bus.address == 4'd8);
  assign wr_dropcnt = bus.write && (bus.address == 4'd9);
  assign unused_wd  = ^bus.writedata[31:16];

  assign accept = rx_valid && !rx_crc_err &&
                  (!filter_en || (rx_dst_port == local_port));

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state. An ack only releases the descriptor in a cycle with no
  // incoming packet; an ack together with an accepted packet re-arms PENDING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                 state_d = PENDING;
      PENDING: if (!rx_valid && w1c_pend)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and per-cycle events
  always_comb begin
    rx_busy = (state_q == PENDING);
    capture = accept && ((state_q == IDLE) || w1c_pend);
    drop    = rx_valid && !capture;
    ovf_set = (state_q == PENDING) && accept && !w1c_pend;
  end

  // Descriptor capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      desc_mac   <= '0;
      desc_ip    <= '0;
      desc_sport <= '0;
      desc_dport <= '0;
      desc_len   <= '0;
      desc_csum  <= '0;
    end else if (capture) begin
      desc_mac   <= rx_src_mac;
      desc_ip    <= rx_src_ip;
      desc_sport <= rx_src_port;
      desc_dport <= rx_dst_port;
      desc_len   <= rx_length;
      desc_csum  <= rx_checksum;
    end
  end

  // Counters: a clear coinciding with an event leaves the counter at 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (wr_rxcnt)     rx_count <= capture ? COUNT_W'(1) : '0;
      else if (capture) rx_count <= sat_inc(rx_count);

      if (wr_dropcnt)   drop_count <= drop ? COUNT_W'(1) : '0;
      else if (drop)    drop_count <= sat_inc(drop_count);
    end
  end

  // Control registers; an overflow event wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      irq_en     <= 1'b0;
      filter_en  <= 1'b0;
      local_port <= LOCAL_PORT_RST;
      irq        <= 1'b0;
    end else begin
      overflow <= (overflow && !w1c_ovf) || ovf_set;
      if (wr_ctrl) begin
        irq_en    <= bus.writedata[8];
        filter_en <= bus.writedata[9];
      end
      if (wr_lport) local_port <= bus.writedata[15:0];
      irq <= irq_en && ((state_q == PENDING) || overflow);
    end
  end

`ifdef AVRX_TIMESTAMP_EN
  logic [COUNT_W-1:0] ts_free, ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_free <= '0;
      ts_q    <= '0;
    end else begin
      ts_free <= ts_free + COUNT_W'(1);
      if (capture) ts_q <= ts_free;
    end
  end

  assign ts_rd = 32'(ts_q);
`else
  assign ts_rd = '0;
`endif

  // Read mux
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      4'd0:    rd_mux = {desc_len, 6'd0, filter_en, irq_en, 6'd0, overflow,
                         (state_q == PENDING)};
      4'd1:    rd_mux = {16'd0, desc_csum};
      4'd2:    rd_mux = {16'd0, local_port};
      4'd3:    rd_mux = {16'd0, desc_sport};
      4'd4:    rd_mux = desc_ip;
      4'd5:    rd_mux = desc_mac[31:0];
      4'd6:    rd_mux = {16'd0, desc_mac[47:32]};
      4'd7:    rd_mux = {16'd0, desc_dport};
      4'd8:    rd_mux = 32'(rx_count);
      4'd9:    rd_mux = 32'(drop_count);
      4'd10:   rd_mux = ts_rd;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held while read is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      bus.readdata <= '0;
    else if (bus.read) bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_av_recvpacket.sv
// ----------------------------------------------------------------------------
// tb_av_recvpacket
// Drives two instances (COUNT_W=32 and COUNT_W=4) with identical stimulus and
// compares them every cycle against a behavioural model of the register block.
// ----------------------------------------------------------------------------
module tb_av_recvpacket;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  av_recvpacket_if bus32();
  av_recvpacket_if bus4();

  assign bus4.address   = bus32.address;
  assign bus4.write     = bus32.write;
  assign bus4.read      = bus32.read;
  assign bus4.writedata = bus32.writedata;

  logic        rx_valid, rx_crc_err;
  logic [47:0] rx_src_mac;
  logic [31:0] rx_src_ip;
  logic [15:0] rx_src_port, rx_dst_port, rx_length, rx_checksum;
  logic        irq32, irq4, busy32, busy4;

  av_recvpacket #(.LOCAL_PORT_RST(16'hAAAA), .COUNT_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(bus32.slave), .irq(irq32),
    .rx_valid(rx_valid), .rx_crc_err(rx_crc_err), .rx_src_mac(rx_src_mac),
    .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port),
    .rx_length(rx_length), .rx_checksum(rx_checksum), .rx_busy(busy32));

  av_recvpacket #(.LOCAL_PORT_RST(16'hAAAA), .COUNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave), .irq(irq4),
    .rx_valid(rx_valid), .rx_crc_err(rx_crc_err), .rx_src_mac(rx_src_mac),
    .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port),
    .rx_length(rx_length), .rx_checksum(rx_checksum), .rx_busy(busy4));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend, m_ovf, m_ien, m_fen, m_irq;
  logic [15:0] m_lport, m_len, m_csum, m_sport, m_dport;
  logic [31:0] m_ip, m_ts;
  logic [47:0] m_mac;
  longint      m_rxc[2], m_dropc[2];
  int          cw[2] = '{32, 4};
  int unsigned m_cyc;
  logic [31:0] exp_rd[2];

  function automatic longint sat_up(input longint c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c < mx) ? c + 1 : c;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a, input int k);
    case (a)
      4'd0:  return {m_len, 6'd0, m_fen, m_ien, 6'd0, m_ovf, m_pend};
      4'd1:  return {16'd0, m_csum};
      4'd2:  return {16'd0, m_lport};
      4'd3:  return {16'd0, m_sport};
      4'd4:  return m_ip;
      4'd5:  return m_mac[31:0];
      4'd6:  return {16'd0, m_mac[47:32]};
      4'd7:  return {16'd0, m_dport};
      4'd8:  return 32'(m_rxc[k]);
      4'd9:  return 32'(m_dropc[k]);
`ifdef AVRX_TIMESTAMP_EN
      4'd10: return (k == 1) ? (m_ts & 32'hF) : m_ts;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ovf = 0; m_ien = 0; m_fen = 0; m_irq = 0;
    m_lport = 16'hAAAA; m_len = 0; m_csum = 0; m_sport = 0; m_dport = 0;
    m_ip = 0; m_mac = 0; m_ts = 0; m_cyc = 0;
    for (int k = 0; k < 2; k++) begin
      m_rxc[k] = 0; m_dropc[k] = 0; exp_rd[k] = 0;
    end
  endtask

  // One clock cycle: update the model from the inputs presented now, let the
  // DUTs see them on the edge, then compare and release the strobes.
  task automatic tick();
    bit acc, w1c0, cap, drp, setov, irq_n;
    logic [31:0] wd;
    wd = bus32.writedata;
    if (bus32.read)
      for (int k = 0; k < 2; k++) exp_rd[k] = model_read(bus32.address, k);
    irq_n = m_ien && (m_pend || m_ovf);
    acc   = rx_valid && !rx_crc_err && (!m_fen || rx_dst_port == m_lport);
    w1c0  = bus32.write && bus32.address == 4'd0 && wd[0];
    cap = 0; drp = 0; setov = 0;
    if (!m_pend) begin
      if (acc) cap = 1;
      else if (rx_valid) drp = 1;
    end else if (rx_valid) begin
      if (acc && w1c0) cap = 1;
      else begin drp = 1; setov = acc; end
    end else if (w1c0) begin
      m_pend = 0;
    end
    if (cap) begin
      m_pend = 1; m_mac = rx_src_mac; m_ip = rx_src_ip; m_sport = rx_src_port;
      m_dport = rx_dst_port; m_len = rx_length; m_csum = rx_checksum; m_ts = m_cyc;
    end
    m_cyc++;
    for (int k = 0; k < 2; k++) begin
      if (bus32.write && bus32.address == 4'd8) m_rxc[k] = cap ? 1 : 0;
      else if (cap) m_rxc[k] = sat_up(m_rxc[k], cw[k]);
      if (bus32.write && bus32.address == 4'd9) m_dropc[k] = drp ? 1 : 0;
      else if (drp) m_dropc[k] = sat_up(m_dropc[k], cw[k]);
    end
    if (bus32.write && bus32.address == 4'd0) begin
      if (wd[1]) m_ovf = 0;
      m_ien = wd[8]; m_fen = wd[9];
    end
    if (setov) m_ovf = 1;
    if (bus32.write && bus32.address == 4'd2) m_lport = wd[15:0];
    m_irq = irq_n;

    @(posedge clk); #1;
    chk("readdata32", bus32.readdata, exp_rd[0]);
    chk("readdata4",  bus4.readdata,  exp_rd[1]);
    chk("irq32",  32'(irq32),  32'(m_irq));
    chk("irq4",   32'(irq4),   32'(m_irq));
    chk("busy32", 32'(busy32), 32'(m_pend));
    chk("busy4",  32'(busy4),  32'(m_pend));
    rx_valid = 0; rx_crc_err = 0; bus32.read = 0; bus32.write = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    rx_valid = 0; rx_crc_err = 0; bus32.read = 0; bus32.write = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata32", bus32.readdata, 32'd0);
    chk("rst_readdata4",  bus4.readdata,  32'd0);
    chk("rst_irq",  32'(irq32 | irq4),   32'd0);
    chk("rst_busy", 32'(busy32 | busy4), 32'd0);
    reset_n = 1;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [31:0] d);
    bus32.address = a; bus32.writedata = d; bus32.write = 1;
  endtask

  task automatic set_pkt(input logic [31:0] ip, input logic [47:0] mac,
                         input logic [15:0] sp, input logic [15:0] dp,
                         input logic [15:0] len, input logic [15:0] cs, input bit crc);
    rx_src_ip = ip; rx_src_mac = mac; rx_src_port = sp; rx_dst_port = dp;
    rx_length = len; rx_checksum = cs; rx_crc_err = crc; rx_valid = 1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    set_wr(a, d); tick();
  endtask

  task automatic rd_expect(input string tag, input logic [3:0] a, input logic [31:0] e32,
                           input logic [31:0] e4);
    bus32.address = a; bus32.read = 1; tick();
    chk({tag, "_32"}, bus32.readdata, e32);
    chk({tag, "_4"},  bus4.readdata,  e4);
  endtask

  initial begin
    bus32.address = 0; bus32.writedata = 0;
    set_pkt(0, 0, 0, 0, 0, 0, 0);
    rx_valid = 0;

    // T1: reset values and local port reset value
    do_reset();
    rd_expect("t1_lport", 4'd2, 32'h0000AAAA, 32'h0000AAAA);
    rd_expect("t1_unused", 4'd13, 32'd0, 32'd0);

    // T2: capture one descriptor
    set_pkt(32'hC0A80005, 48'hD4BDD93049D0, 16'hFDE2, 16'h0050, 16'd64, 16'hBEEF, 0);
    tick();
    chk("t2_busy", 32'(busy32), 32'd1);
    rd_expect("t2_ip",    4'd4, 32'hC0A80005, 32'hC0A80005);
    rd_expect("t2_maclo", 4'd5, 32'hD93049D0, 32'hD93049D0);
    rd_expect("t2_machi", 4'd6, 32'h0000D4BD, 32'h0000D4BD);
    rd_expect("t2_sport", 4'd3, 32'h0000FDE2, 32'h0000FDE2);
    rd_expect("t2_ctrl",  4'd0, 32'h00400001, 32'h00400001);
    rd_expect("t2_rxcnt", 4'd8, 32'd1, 32'd1);
    rd_expect("t2_csum",  4'd1, 32'h0000BEEF, 32'h0000BEEF);

    // T3: overflow while pending, irq, ack
    do_reset();
    do_write(4'd0, 32'h100);
    set_pkt(32'h0A000001, 48'h111111111111, 16'h1000, 16'h2000, 16'd100, 16'h1111, 0);
    tick();
    set_pkt(32'h0A000002, 48'h222222222222, 16'h3000, 16'h4000, 16'd200, 16'h2222, 0);
    tick();
    rd_expect("t3_drop", 4'd9, 32'd1, 32'd1);
    rd_expect("t3_ctrl", 4'd0, 32'h00640103, 32'h00640103);
    rd_expect("t3_ip",   4'd4, 32'h0A000001, 32'h0A000001);
    chk("t3_irq_on", 32'(irq32), 32'd1);
    do_write(4'd0, 32'h103);
    tick();
    chk("t3_irq_off", 32'(irq32), 32'd0);

    // T4: filter mismatch and CRC error are dropped
    do_reset();
    do_write(4'd0, 32'h200);
    do_write(4'd2, 32'h1234);
    set_pkt(32'h01020304, 48'h0, 16'h1, 16'h5678, 16'd8, 16'h0, 0);
    tick();
    chk("t4_idle", 32'(busy32), 32'd0);
    rd_expect("t4_drop1", 4'd9, 32'd1, 32'd1);
    set_pkt(32'h01020304, 48'h0, 16'h1, 16'h1234, 16'd8, 16'h0, 1);
    tick();
    rd_expect("t4_drop2", 4'd9, 32'd2, 32'd2);
    rd_expect("t4_ctrl",  4'd0, 32'h00000200, 32'h00000200);

    // T5: ack and accepted packet in the same cycle
    do_reset();
    set_pkt(32'h0B000001, 48'hAAAAAAAAAAAA, 16'h1, 16'h2, 16'd10, 16'h3, 0);
    tick();
    set_pkt(32'h0B000002, 48'hBBBBBBBBBBBB, 16'h4, 16'h5, 16'd20, 16'h6, 0);
    set_wr(4'd0, 32'h1);
    tick();
    rd_expect("t5_ctrl",  4'd0, 32'h00140001, 32'h00140001);
    rd_expect("t5_rxcnt", 4'd8, 32'd2, 32'd2);
    rd_expect("t5_ip",    4'd4, 32'h0B000002, 32'h0B000002);

    // T6: saturation (COUNT_W=4) and clear-with-increment
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_pkt(32'h0, 48'h0, 16'h0, 16'h0, 16'd0, 16'h0, 1);
      tick();
    end
    rd_expect("t6_sat", 4'd9, 32'd20, 32'd15);
    set_pkt(32'h0, 48'h0, 16'h0, 16'h0, 16'd0, 16'h0, 1);
    set_wr(4'd9, 32'h0);
    tick();
    rd_expect("t6_clrinc", 4'd9, 32'd1, 32'd1);
    rd_expect("t6_ts", 4'd10, model_read(4'd10, 0), model_read(4'd10, 1));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int op;
      if (i % 1300 == 1299) do_reset();
      if ($urandom_range(0, 99) < 35)
        set_pkt($urandom, {$urandom, $urandom}, 16'($urandom),
                ($urandom_range(0, 1) != 0) ? 16'h1234 : 16'h5678,
                16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: begin bus32.address = 4'($urandom); bus32.read = 1; end
        4, 5: set_wr(4'd0, {22'd0, 1'($urandom), 1'($urandom), 6'd0,
                            1'($urandom), 1'($urandom)});
        6: set_wr(4'd2, ($urandom_range(0, 1) != 0) ? 32'h1234 : 32'h5678);
        7: set_wr(($urandom_range(0, 1) != 0) ? 4'd8 : 4'd9, $urandom);
        8: set_wr(4'($urandom_range(1, 15)), $urandom);
        default: ;
      endcase
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
